val_rdy_profile_counter: RTL and testbench
==========================================

Name: val_rdy_profile_counter

Overview:
- Synthesizable cycle profiler that watches one val/rdy handshake in the backprop pipeline.
- Classifies every cycle as IDLE, STALL or XFER and accumulates a saturating counter per class.
- On a snapshot request it freezes the counts and streams them out over its own val/rdy channel to the downstream host/debug readout stage.
- Counting keeps running while a snapshot streams out, so no cycles are lost.

Parameters:
- CNT_W, 32, width of each class counter and of out_data.
- ID, 0, 8-bit stage identifier carried on out_id.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low.
- mon_val  input  1  monitored stage valid.
- mon_rdy  input  1  monitored stage ready.
- snap  input  1  snapshot request pulse.
- out_data  output  CNT_W  counter word.
- out_tag  output  2  0=IDLE, 1=STALL, 2=XFER, 3=TOTAL (TOTAL only with the optional feature).
- out_sat  output  1  the word on out_data saturated.
- out_id  output  8  constant ID.
- out_val  output  1  word valid.
- out_rdy  input  1  downstream ready.
- snap_drop  output  1  one-cycle pulse when snap is ignored.

Behaviour:
- Cycle class:
  - IDLE = !mon_val.
  - STALL = mon_val && !mon_rdy.
  - XFER = mon_val && mon_rdy.
  - Exactly one live counter increments per cycle.
- Live counters saturate at 2^CNT_W-1. A sticky sat bit per counter is set when an increment is attempted at max.
- Reset (rst==0 at posedge):
  - All live counters, shadow registers and sat bits are 0.
  - FSM goes to COUNT.
  - out_val=0, out_data=0, out_tag=0, out_sat=0, snap_drop=0.
  - Reset mid-stream abandons the snapshot; no further words are sent.
- FSM states: COUNT, SEND_IDLE, SEND_STALL, SEND_XFER, plus SEND_TOTAL with the optional feature.
- COUNT with snap=1:
  - Shadow registers take the live counters and sat bits as they were before this cycle's increment.
  - Live counters reload to 0 plus this cycle's increment; the snap cycle belongs to the new window.
  - Sat bits clear.
  - Next state is SEND_IDLE.
- SEND_x states:
  - out_val=1; out_data, out_tag and out_sat come from the shadow word.
  - Outputs stay stable until out_val && out_rdy.
  - On handshake, advance to the next SEND state. From the last SEND state, return to COUNT.
  - Back-to-back accepts give one word per cycle. Minimum snapshot length is 3 cycles (4 with the optional feature).
- snap while in any SEND state:
  - Ignored; shadow registers and live counters are untouched.
  - snap_drop=1 for that cycle.
- snap on the same cycle as the final handshake: ignored and dropped. A new snap is accepted only in COUNT.
- Latency: first word valid on the cycle after snap is sampled.
- No combinational path from out_rdy to out_val.

Optional Feature:
- Macro: PROFILE_TOTAL_EN.
- Defined:
  - Adds a CNT_W+2 bit total-cycle accumulator, and a SEND_TOTAL state after SEND_XFER.
  - out_tag=3; out_data = min(IDLE+STALL+XFER shadows, 2^CNT_W-1).
  - out_sat is set if the sum clipped or any shadow sat bit was set.
- Undefined:
  - No total logic; SEND_XFER returns to COUNT.
  - Tag 3 is never emitted.

Test Plan:
- Reset, then 10 cycles idle (mon_val=0), snap, out_rdy=1:
  - words (tag0,10), (tag1,0), (tag2,0) on 3 consecutive cycles.
  - with PROFILE_TOTAL_EN, a 4th word (tag3,10).
- 4 cycles mon_val=1/mon_rdy=0, then 6 cycles mon_val=1/mon_rdy=1, then snap while mon_val=1/mon_rdy=1 -> words IDLE=0, STALL=4, XFER=6; a second immediate window shows XFER counted from 1 (the snap cycle).
- Snapshot with out_rdy held 0 for 5 cycles, while mon_val=1/mon_rdy=1:
  - out_val=1 and IDLE word stable throughout.
  - after the snapshot completes, a new snap reports XFER ≥ 5.
- Snap pulsed during SEND_STALL -> snap_drop=1 for one cycle; stream continues unchanged; shadows unmodified.
- CNT_W=4, 20 idle cycles, snap -> IDLE word 15, out_sat=1; STALL/XFER words out_sat=0.
- rst=0 asserted mid-stream after the first word is accepted -> next cycle out_val=0; subsequent snap after 3 idle cycles reports IDLE=3.

Source files
------------

// File: rtl/val_rdy_profile_counter.sv
// Cycle profiler for one val/rdy handshake: IDLE/STALL/XFER saturating counters, snapshot streamed out on a val/rdy port.
// Optional macro PROFILE_TOTAL_EN appends a clipped TOTAL word (tag 3) after the XFER word.
module val_rdy_profile_counter #(
  parameter int         CNT_W = 32,
  parameter logic [7:0] ID    = 8'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_val,
  input  logic             mon_rdy,
  input  logic             snap,
  output logic [CNT_W-1:0] out_data,
  output logic [1:0]       out_tag,
  output logic             out_sat,
  output logic [7:0]       out_id,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             snap_drop
);

  typedef enum logic [2:0] {
    COUNT      = 3'd0,
    SEND_IDLE  = 3'd1,
    SEND_STALL = 3'd2,
    SEND_XFER  = 3'd3,
    SEND_TOTAL = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r [3];
  logic [2:0]       sat_r;
  logic [CNT_W-1:0] sh_stall_r;
  logic [CNT_W-1:0] sh_xfer_r;
  logic [2:1]       sh_sat_r;
  logic [CNT_W-1:0] out_data_r;
  logic [1:0]       out_tag_r;
  logic             out_sat_r;
  logic             out_val_r;
  logic             snap_drop_r;
  logic [2:0]       inc_s;
  logic             take_s;
`ifdef PROFILE_TOTAL_EN
  logic [CNT_W-1:0] sh_idle_r;
  logic             sh_sat_idle_r;
  logic [CNT_W+1:0] total_s;
  logic             clip_s;
`endif

  // Cycle classification and snapshot acceptance
  always_comb begin
    inc_s  = {mon_val && mon_rdy, mon_val && !mon_rdy, !mon_val};
    take_s = (state_r == COUNT) && snap;
`ifdef PROFILE_TOTAL_EN
    total_s = {2'b00, sh_idle_r} + {2'b00, sh_stall_r} + {2'b00, sh_xfer_r};
    clip_s  = |total_s[CNT_W+1:CNT_W];
`endif
  end

  // Live counters; the snap cycle itself opens the new window
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) cnt_r[i] <= CNT_ZERO;
      sat_r <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (take_s) begin
          cnt_r[i] <= inc_s[i] ? CNT_ONE : CNT_ZERO;
          sat_r[i] <= 1'b0;
        end else if (inc_s[i]) begin
          if (cnt_r[i] == CNT_MAX) sat_r[i] <= 1'b1;
          else                     cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Snapshot FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= COUNT;
      sh_stall_r  <= CNT_ZERO;
      sh_xfer_r   <= CNT_ZERO;
      sh_sat_r    <= 2'b00;
      out_val_r   <= 1'b0;
      out_data_r  <= CNT_ZERO;
      out_tag_r   <= 2'd0;
      out_sat_r   <= 1'b0;
      snap_drop_r <= 1'b0;
`ifdef PROFILE_TOTAL_EN
      sh_idle_r     <= CNT_ZERO;
      sh_sat_idle_r <= 1'b0;
`endif
    end else begin
      snap_drop_r <= snap && (state_r != COUNT);
      case (state_r)
        COUNT: begin
          if (take_s) begin
            sh_stall_r <= cnt_r[1];
            sh_xfer_r  <= cnt_r[2];
            sh_sat_r   <= sat_r[2:1];
`ifdef PROFILE_TOTAL_EN
            sh_idle_r     <= cnt_r[0];
            sh_sat_idle_r <= sat_r[0];
`endif
            out_val_r  <= 1'b1;
            out_data_r <= cnt_r[0];
            out_tag_r  <= 2'd0;
            out_sat_r  <= sat_r[0];
            state_r    <= SEND_IDLE;
          end
        end
        SEND_IDLE: begin
          if (out_rdy) begin
            out_data_r <= sh_stall_r;
            out_tag_r  <= 2'd1;
            out_sat_r  <= sh_sat_r[1];
            state_r    <= SEND_STALL;
          end
        end
        SEND_STALL: begin
          if (out_rdy) begin
            out_data_r <= sh_xfer_r;
            out_tag_r  <= 2'd2;
            out_sat_r  <= sh_sat_r[2];
            state_r    <= SEND_XFER;
          end
        end
        SEND_XFER: begin
          if (out_rdy) begin
`ifdef PROFILE_TOTAL_EN
            out_data_r <= clip_s ? CNT_MAX : total_s[CNT_W-1:0];
            out_tag_r  <= 2'd3;
            out_sat_r  <= clip_s || sh_sat_idle_r || (|sh_sat_r);
            state_r    <= SEND_TOTAL;
`else
            out_val_r  <= 1'b0;
            out_data_r <= CNT_ZERO;
            out_tag_r  <= 2'd0;
            out_sat_r  <= 1'b0;
            state_r    <= COUNT;
`endif
          end
        end
`ifdef PROFILE_TOTAL_EN
        SEND_TOTAL: begin
          if (out_rdy) begin
            out_val_r  <= 1'b0;
            out_data_r <= CNT_ZERO;
            out_tag_r  <= 2'd0;
            out_sat_r  <= 1'b0;
            state_r    <= COUNT;
          end
        end
`endif
        default: begin
          out_val_r <= 1'b0;
          state_r   <= COUNT;
        end
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_tag   = out_tag_r;
  assign out_sat   = out_sat_r;
  assign out_val   = out_val_r;
  assign out_id    = ID;
  assign snap_drop = snap_drop_r;

endmodule

// File: tb/tb_val_rdy_profile_counter.sv
// Scoreboard bench for val_rdy_profile_counter; a cycle model pushes expected words at each accepted snap.
module tb_val_rdy_profile_counter;

`ifdef PROFILE_TOTAL_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif
  localparam logic [7:0] TB_ID = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mon_val = 1'b0, mon_rdy = 1'b0, snap = 1'b0, out_rdy = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        out_sat, out_val, snap_drop;
  logic [7:0]  out_id;
  logic [3:0]  s_data;
  logic [1:0]  s_tag;
  logic        s_sat, s_val, s_drop;
  logic [7:0]  s_id;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] sb [$];
  int m_cnt [3];
  int m_busy = 0;
  logic exp_drop = 1'b0;

  always #5 clk = ~clk;

  val_rdy_profile_counter #(.CNT_W(32), .ID(TB_ID)) dut (
    .clk(clk), .rst(rst), .mon_val(mon_val), .mon_rdy(mon_rdy), .snap(snap),
    .out_data(out_data), .out_tag(out_tag), .out_sat(out_sat), .out_id(out_id),
    .out_val(out_val), .out_rdy(out_rdy), .snap_drop(snap_drop));

  val_rdy_profile_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mon_val(mon_val), .mon_rdy(mon_rdy), .snap(snap),
    .out_data(s_data), .out_tag(s_tag), .out_sat(s_sat), .out_id(s_id),
    .out_val(s_val), .out_rdy(out_rdy), .snap_drop(s_drop));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop and compare every accepted word
  always @(negedge clk) begin
    if (rst && out_val && out_rdy) begin
      if (sb.size() == 0) check("unexpected_word", 64'd1, 64'd0);
      else check("word", {29'd0, out_sat, out_tag, out_data}, {29'd0, sb.pop_front()});
    end
  end

  task automatic push_snapshot();
    int tot;
    tot = m_cnt[0] + m_cnt[1] + m_cnt[2];
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, 2'(i), 32'(m_cnt[i])});
`ifdef PROFILE_TOTAL_EN
    sb.push_back({1'b0, 2'd3, 32'(tot)});
`endif
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      logic r, s, orr;
      int cls, b0;
      @(posedge clk);
      r = rst; s = snap; orr = out_rdy; b0 = m_busy;
      cls = !mon_val ? 0 : (!mon_rdy ? 1 : 2);
      if (!r) begin
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_busy = 0;
        exp_drop = 1'b0;
        sb.delete();
      end else begin
        exp_drop = s && (b0 > 0);
        if (b0 > 0 && orr) m_busy = b0 - 1;
        if (s && b0 == 0) begin
          push_snapshot();
          for (int i = 0; i < 3; i++) m_cnt[i] = 0;
          m_busy = NW;
        end
        m_cnt[cls] = m_cnt[cls] + 1;
      end
      #1;
      check("out_val", {63'd0, out_val}, {63'd0, m_busy > 0});
      check("snap_drop", {63'd0, snap_drop}, {63'd0, exp_drop});
      if (!r) check("reset_outs", {29'd0, out_sat, out_tag, out_data}, 64'd0);
    end
  endtask

  task automatic do_snap();
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
  endtask

  initial begin
    logic [34:0] head;
    // reset, then 10 idle cycles and a snapshot
    cyc(2);
    check("out_id", {56'd0, out_id}, {56'd0, TB_ID});
    rst = 1'b1;
    cyc(10);
    do_snap();
    cyc(NW);
    // 4 stall + 6 xfer, snap on an xfer cycle, then an immediate second window
    mon_val = 1'b1; mon_rdy = 1'b0;
    cyc(4);
    mon_rdy = 1'b1;
    cyc(6);
    do_snap();
    cyc(NW);
    do_snap();
    cyc(NW);
    // downstream back-pressure for 5 cycles while transfers keep counting
    out_rdy = 1'b0;
    do_snap();
    head = sb[0];
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("hold_word", {29'd0, out_sat, out_tag, out_data}, {29'd0, head});
    end
    out_rdy = 1'b1;
    cyc(NW);
    do_snap();
    cyc(NW);
    // snap during SEND_STALL and on the final handshake are both dropped
    mon_val = 1'b0;
    do_snap();
    cyc(1);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    cyc(NW - 3);
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
    cyc(2);
    do_snap();
    cyc(NW);
    // random mix of monitored traffic, back-pressure and snap pulses
    for (int k = 0; k < 300; k++) begin
      mon_val = 1'($urandom_range(0, 1));
      mon_rdy = 1'($urandom_range(0, 1));
      out_rdy = ($urandom_range(0, 3) != 0);
      snap    = ($urandom_range(0, 7) == 0);
      cyc(1);
    end
    snap = 1'b0; out_rdy = 1'b1;
    cyc(NW + 1);
    // reset mid-stream after the first word is accepted
    mon_val = 1'b0;
    do_snap();
    cyc(1);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(3);
    do_snap();
    cyc(NW);
    // 4-bit instance: 20 idle cycles saturate the IDLE counter
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(20);
    do_snap();
    check("sat_w0", {57'd0, s_val, s_sat, s_tag, s_data}, {57'd0, 1'b1, 1'b1, 2'd0, 4'd15});
    cyc(1);
    check("sat_w1", {57'd0, s_val, s_sat, s_tag, s_data}, {57'd0, 1'b1, 1'b0, 2'd1, 4'd0});
    cyc(1);
    check("sat_w2", {57'd0, s_val, s_sat, s_tag, s_data}, {57'd0, 1'b1, 1'b0, 2'd2, 4'd0});
    cyc(NW);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
